// File: rtl/iso_cmd_sequencer_if.sv
// Command port between the sequencer and the cryptoprocessor datapath.
//   cmd_valid : command on cmd_out is valid (sequencer -> datapath)
//   cmd_out   : command word {INS[2:0], rd1, rd2, wr}
//   dp_ready  : datapath accepts cmd_out this cycle (datapath -> sequencer)
// A command is transferred on a cycle where cmd_valid and dp_ready are both high.
interface iso_cmd_sequencer_if #(
  parameter int AW = 7
);
  localparam int CMD_W = 3 + 3*AW;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_out;
  logic             dp_ready;

  modport master (output cmd_valid, output cmd_out, input dp_ready);
  modport slave  (input cmd_valid, input cmd_out, output dp_ready);
endinterface

// File: rtl/iso_cmd_sequencer.sv
// Command sequencer: replays a stored command range [pc_start, pc_end] from an
// on-chip program memory loop_cnt times into the datapath command port. A
// latency scoreboard stalls issue on read-after-write, write-after-write and
// write-back-slot collisions.
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   prog_we/addr/data : program memory write port (ignored while busy)
//   start             : start pulse, with pc_start, pc_end, loop_cnt
//   busy              : high from accepted start until done
//   done, err         : one-cycle completion / error pulses
//   cmd               : command handshake (master side of iso_cmd_sequencer_if)
//
// Optional build macro SEQ_PERF_EN adds issue_cnt[31:0] (accepted commands) and
// stall_cnt[31:0] (RUN cycles with a legal command waiting). Both clear on reset
// and on an accepted start, saturate, and hold after done.
module iso_cmd_sequencer #(
  parameter int AW       = 7,
  parameter int PA_W     = 6,
  parameter int LOOP_W   = 16,
  parameter int MUL_LAT  = 4,
  parameter int ALU_LAT  = 1,
  localparam int CMD_W   = 3 + 3*AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [PA_W-1:0]   prog_addr,
  input  logic [CMD_W-1:0]  prog_data,
  input  logic              start,
  input  logic [PA_W-1:0]   pc_start,
  input  logic [PA_W-1:0]   pc_end,
  input  logic [LOOP_W-1:0] loop_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef SEQ_PERF_EN
  output logic [31:0]       issue_cnt,
  output logic [31:0]       stall_cnt,
`endif
  iso_cmd_sequencer_if.master cmd
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] addr;
  } sb_entry_t;

  localparam logic [2:0] INS_NOP  = 3'd0;
  localparam logic [2:0] INS_COPY = 3'd2;
  localparam logic [2:0] INS_ADD  = 3'd3;
  localparam logic [2:0] INS_SUB  = 3'd4;
  localparam logic [2:0] INS_MUL  = 3'd5;

  state_t                  state_q, state_d;
  logic [PA_W-1:0]         pc_q, pc_d, pcs_q, pcs_d, pce_q, pce_d;
  logic [LOOP_W-1:0]       loops_q, loops_d;
  sb_entry_t [MUL_LAT-1:0] sb_q, sb_shift, sb_d;
  logic                    held_q, err_d;

  logic [CMD_W-1:0] cur_cmd;
  logic [2:0]       ins;
  logic [AW-1:0]    rd1, rd2, wr;
  logic             is_nop, is_op, is_mul, hazard, sb_empty, start_ok, accept;

  // Program store.
  logic [CMD_W-1:0] mem [2**PA_W];

  // NOTE: the program array has no reset; it is a RAM and must keep its
  // contents across a sequencer reset, so only the write strobe is gated.
  always_ff @(posedge clk) begin
    if (rst && prog_we && !busy) mem[prog_addr] <= prog_data;
  end

  assign cur_cmd = mem[pc_q];
  assign ins     = cur_cmd[CMD_W-1 -: 3];
  assign rd1     = cur_cmd[3*AW-1 -: AW];
  assign rd2     = cur_cmd[2*AW-1 -: AW];
  assign wr      = cur_cmd[AW-1:0];
  assign is_nop  = (ins == INS_NOP);
  assign is_mul  = (ins == INS_MUL);
  assign is_op   = ins inside {INS_COPY, INS_ADD, INS_SUB, INS_MUL};

  assign start_ok = (state_q == S_IDLE) && start && (pc_start <= pc_end);
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

  // Hazards are judged against the scoreboard as it will be after this
  // cycle's shift, so an entry retiring in slot 0 never blocks.
  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin : sb_view
    sb_shift = '0;
    hazard   = 1'b0;
    sb_empty = 1'b1;
    for (int i = 0; i < MUL_LAT-1; i++) sb_shift[i] = sb_q[i+1];
    for (int i = 0; i < MUL_LAT; i++) begin
      if (sb_q[i].v) sb_empty = 1'b0;
      if (sb_shift[i].v && ((sb_shift[i].addr == rd1) || (sb_shift[i].addr == wr) ||
                            ((ins != INS_COPY) && (sb_shift[i].addr == rd2))))
        hazard = 1'b1;
    end
    // Write-port collision at the slot this command would occupy.
    if (is_mul ? sb_shift[MUL_LAT-1].v : sb_shift[ALU_LAT-1].v) hazard = 1'b1;
  end

  // Once presented, a command stays valid until accepted. RAW/WAW hazards can
  // only clear over time; a slot collision that slides in under back-pressure
  // is judged at first presentation only, keeping the handshake stable.
  assign cmd.cmd_valid = (state_q == S_RUN) && is_op && (held_q || !hazard);
  assign cmd.cmd_out   = cmd.cmd_valid ? cur_cmd : '0;
  assign accept        = cmd.cmd_valid && cmd.dp_ready;

  always_comb begin : sb_next
    sb_d = sb_shift;
    if (accept) begin
      if (is_mul) sb_d[MUL_LAT-1] = '{v: 1'b1, addr: wr};
      else        sb_d[ALU_LAT-1] = '{v: 1'b1, addr: wr};
    end
  end

  always_comb begin : fsm_next
    logic advance;
    advance = 1'b0;
    state_d = state_q;
    pc_d    = pc_q;
    pcs_d   = pcs_q;
    pce_d   = pce_q;
    loops_d = loops_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          pc_d    = pc_start;
          pcs_d   = pc_start;
          pce_d   = pc_end;
          loops_d = (loop_cnt == '0) ? LOOP_W'(1) : loop_cnt;
          state_d = S_RUN;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        if (is_nop) begin
          advance = 1'b1;
        end else if (!is_op) begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (accept) begin
          advance = 1'b1;
        end
        if (advance) begin
          if (pc_q == pce_q) begin
            if (loops_q > LOOP_W'(1)) begin
              pc_d    = pcs_q;
              loops_d = loops_q - LOOP_W'(1);
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            pc_d = pc_q + PA_W'(1);
          end
        end
      end
      S_DRAIN: if (sb_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      pcs_q   <= '0;
      pce_q   <= '0;
      loops_q <= '0;
      sb_q    <= '0;
      held_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcs_q   <= pcs_d;
      pce_q   <= pce_d;
      loops_q <= loops_d;
      sb_q    <= sb_d;
      held_q  <= cmd.cmd_valid && !cmd.dp_ready;
      err     <= err_d;
    end
  end

`ifdef SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst || start_ok) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && (issue_cnt != '1)) issue_cnt <= issue_cnt + 32'd1;
      if ((state_q == S_RUN) && is_op && !accept && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iso_cmd_sequencer.sv
// Directed self-checking bench for iso_cmd_sequencer (default parameters).
module tb_iso_cmd_sequencer;
  localparam int AW = 7, PA_W = 6, LOOP_W = 16, CMD_W = 3 + 3*AW;
  localparam logic [2:0] NOP = 3'd0, COPY = 3'd2, ADD = 3'd3, SUB = 3'd4, MUL = 3'd5;

  logic              clk = 1'b0, rst = 1'b0, prog_we = 1'b0, start = 1'b0;
  logic [PA_W-1:0]   prog_addr = '0, pc_start = '0, pc_end = '0;
  logic [CMD_W-1:0]  prog_data = '0;
  logic [LOOP_W-1:0] loop_cnt = '0;
  logic              busy, done, err;
`ifdef SEQ_PERF_EN
  logic [31:0]       issue_cnt, stall_cnt;
`endif

  iso_cmd_sequencer_if #(.AW(AW)) cmd_if ();

  iso_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .pc_start  (pc_start),
    .pc_end    (pc_end),
    .loop_cnt  (loop_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
`ifdef SEQ_PERF_EN
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt),
`endif
    .cmd       (cmd_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log of accepted commands with the cycle they were accepted in.
  logic [CMD_W-1:0] issued_q [$];
  int               issued_cyc [$];
  int               done_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (cmd_if.cmd_valid === 1'b1 && cmd_if.dp_ready === 1'b1) begin
      issued_q.push_back(cmd_if.cmd_out);
      issued_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1)  err_cnt  <= err_cnt + 1;
  end

  int n_vec = 0, n_err = 0;
  logic [CMD_W-1:0] prog_a [4];
  logic [CMD_W-1:0] prog_iso [11];
  logic [CMD_W-1:0] exp_q [$];

  function automatic logic [CMD_W-1:0] mk(input logic [2:0] ins, input int r1,
                                          input int r2, input int w);
    return {ins, AW'(r1), AW'(r2), AW'(w)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [CMD_W-1:0] data);
    prog_we = 1'b1; prog_addr = PA_W'(addr); prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic run_start(input int ps, input int pe, input int lc);
    pc_start = PA_W'(ps); pc_end = PA_W'(pe); loop_cnt = LOOP_W'(lc); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, " done seen"}, done, 1'b1);
    check({tag, " busy low at done"}, busy, 1'b0);
    tick();
    check({tag, " done one cycle"}, done, 1'b0);
  endtask

  // Compares the commands logged since index base against exp_q.
  task automatic check_stream(input string tag, input int base);
    check({tag, " issue count"}, issued_q.size() - base, exp_q.size());
    if (issued_q.size() - base == exp_q.size())
      foreach (exp_q[i]) check($sformatf("%s cmd%0d", tag, i), issued_q[base+i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, d0, e0, t0;
    cmd_if.dp_ready = 1'b1;
    prog_a[0] = mk(SUB, 0, 1, 5);
    prog_a[1] = mk(ADD, 0, 1, 6);
    prog_a[2] = mk(MUL, 1, 1, 4);
    prog_a[3] = mk(ADD, 4, 4, 4);
    prog_iso[0]  = mk(SUB, 10, 11, 20);
    prog_iso[1]  = mk(ADD, 10, 11, 21);
    prog_iso[2]  = mk(MUL, 11, 11, 22);
    prog_iso[3]  = mk(ADD, 22, 22, 22);
    prog_iso[4]  = mk(MUL, 22, 22, 23);
    prog_iso[5]  = mk(ADD, 22, 22, 24);
    prog_iso[6]  = mk(MUL, 10, 10, 25);
    prog_iso[7]  = mk(ADD, 25, 25, 25);
    prog_iso[8]  = mk(MUL, 25, 25, 26);
    prog_iso[9]  = mk(COPY, 26, 0, 27);
    prog_iso[10] = mk(SUB, 20, 21, 28);

    // Reset state.
    repeat (3) tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset cmd_valid", cmd_if.cmd_valid, 1'b0);
    check("reset cmd_out", cmd_if.cmd_out, '0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) load(i, prog_a[i]);

    // Single pass with a MUL read-after-write stall.
    base = issued_q.size(); d0 = done_cnt; e0 = err_cnt;
    run_start(0, 3, 1);
    t0 = cyc;
    check("t1 busy", busy, 1'b1);
    check("t1 first valid", cmd_if.cmd_valid, 1'b1);
    wait_done("t1", 60);
    exp_q = {prog_a[0], prog_a[1], prog_a[2], prog_a[3]};
    check_stream("t1", base);
    if (issued_cyc.size() == base + 4) begin
      check("t1 cmd0 latency", issued_cyc[base] - t0, 0);
      check("t1 cmd1 gap", issued_cyc[base+1] - issued_cyc[base], 1);
      check("t1 cmd2 gap", issued_cyc[base+2] - issued_cyc[base+1], 1);
      check("t1 mul to dep gap", issued_cyc[base+3] - issued_cyc[base+2], 4);
    end
    check("t1 done count", done_cnt - d0, 1);
    check("t1 no err", err_cnt - e0, 0);
`ifdef SEQ_PERF_EN
    check("t1 issue_cnt", issue_cnt, 4);
    check("t1 stall_cnt", stall_cnt, 3);
`endif

    // Back-pressure on command 1 for five cycles.
    base = issued_q.size();
    run_start(0, 3, 1);
    check("bp cmd0 valid", cmd_if.cmd_valid, 1'b1);
    tick();
    cmd_if.dp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold valid %0d", i), cmd_if.cmd_valid, 1'b1);
      check($sformatf("bp hold cmd %0d", i), cmd_if.cmd_out, prog_a[1]);
      tick();
    end
    cmd_if.dp_ready = 1'b1;
    check("bp release cmd", cmd_if.cmd_out, prog_a[1]);
    wait_done("bp", 60);
    check_stream("bp", base);

    // Illegal code inside the program.
    load(1, mk(3'd6, 0, 1, 6));
    base = issued_q.size(); d0 = done_cnt; e0 = err_cnt;
    run_start(0, 3, 1);
    wait_done("ill", 60);
    exp_q = {prog_a[0]};
    check_stream("ill", base);
    check("ill err pulses", err_cnt - e0, 1);
    check("ill done count", done_cnt - d0, 1);

    // NOP consumes one cycle without issuing.
    load(1, mk(NOP, 0, 0, 0));
    base = issued_q.size(); e0 = err_cnt;
    run_start(0, 3, 1);
    wait_done("nop", 60);
    exp_q = {prog_a[0], prog_a[2], prog_a[3]};
    check_stream("nop", base);
    if (issued_cyc.size() == base + 3) begin
      check("nop gap", issued_cyc[base+1] - issued_cyc[base], 2);
      check("nop mul gap", issued_cyc[base+2] - issued_cyc[base+1], 4);
    end
    check("nop no err", err_cnt - e0, 0);
    load(1, prog_a[1]);

    // Reset during the MUL stall, then restart on the stalled command.
    base = issued_q.size();
    run_start(0, 3, 1);
    repeat (3) tick();
    check("rmr stalled", cmd_if.cmd_valid, 1'b0);
    check("rmr issued before reset", issued_q.size() - base, 3);
    rst = 1'b0;
    tick();
    check("rmr busy", busy, 1'b0);
    check("rmr cmd_valid", cmd_if.cmd_valid, 1'b0);
    check("rmr cmd_out", cmd_if.cmd_out, '0);
    check("rmr done", done, 1'b0);
    rst = 1'b1;
    base = issued_q.size();
    run_start(3, 3, 1);
    check("rmr restart valid", cmd_if.cmd_valid, 1'b1);
    check("rmr restart cmd", cmd_if.cmd_out, prog_a[3]);
    wait_done("rmr3", 40);
    exp_q = {prog_a[3]};
    check_stream("rmr3", base);
    base = issued_q.size();
    run_start(0, 0, 1);
    wait_done("rmr0", 40);
    exp_q = {prog_a[0]};
    check_stream("rmr0", base);

    // Reversed range.
    e0 = err_cnt;
    run_start(5, 2, 1);
    check("range err", err, 1'b1);
    check("range busy", busy, 1'b0);
    tick();
    check("range err pulse", err, 1'b0);
    check("range still idle", busy, 1'b0);
    check("range err count", err_cnt - e0, 1);

    // start and prog_we while busy are dropped.
    base = issued_q.size(); d0 = done_cnt;
    run_start(0, 3, 1);
    tick();
    pc_start = 3; pc_end = 3; loop_cnt = 5; start = 1'b1;
    prog_we = 1'b1; prog_addr = 0; prog_data = mk(COPY, 9, 9, 9);
    tick();
    start = 1'b0; prog_we = 1'b0;
    wait_done("busy", 60);
    exp_q = {prog_a[0], prog_a[1], prog_a[2], prog_a[3]};
    check_stream("busy", base);
    check("busy done count", done_cnt - d0, 1);
    base = issued_q.size();
    run_start(0, 0, 0);
    wait_done("mem kept", 40);
    exp_q = {prog_a[0]};
    check_stream("mem kept", base);

    // Full 11-command program, three passes.
    for (int i = 0; i < 11; i++) load(i, prog_iso[i]);
    base = issued_q.size(); d0 = done_cnt;
    run_start(0, 10, 3);
    wait_done("iso", 600);
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 11; i++) exp_q.push_back(prog_iso[i]);
    check_stream("iso", base);
    check("iso done count", done_cnt - d0, 1);
`ifdef SEQ_PERF_EN
    check("iso issue_cnt", issue_cnt, 33);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
